// File: rtl/mem_responder.sv
// mem_responder: wait-stated word memory answering the MAR/MDR Enable/RW handshake with MFC.
// Latency: accept on the first edge Enable is seen high in IDLE; MFC rises WAIT_CYC edges later.
// Backpressure: four-phase; MFC holds until Enable drops, then one RELEASE cycle before the next accept.
// Optional feature macro MEM_BOUNDS_EN: out-of-range accesses raise err instead of aliasing modulo DEPTH.
module mem_responder #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 8,
  parameter int DEPTH    = 256,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Enable,
  input  logic              RW,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              MFC,
  output logic              busy
`ifdef MEM_BOUNDS_EN
  ,
  output logic              err
`endif
);

  localparam int IDX_W = (DEPTH < 2) ? 1 : $clog2(DEPTH);
  localparam int CNT_W = (WAIT_CYC < 2) ? 1 : $clog2(WAIT_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DONE    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              lat_rw;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  // Set when the initiator let go of Enable before DONE; suppresses MFC for this access.
  logic              aborted;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              cur_rw;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic              enter_done;
  logic              mfc_on;
  logic [IDX_W-1:0]  acc_idx;
  logic              acc_oob;
  logic              mem_we;

  // Request fields: live inputs on the accept edge (needed when WAIT_CYC=0), latched copy afterwards.
  always_comb begin
    cur_rw    = lat_rw;
    cur_addr  = lat_addr;
    cur_wdata = lat_wdata;
    if (state == S_IDLE) begin
      cur_rw    = RW;
      cur_addr  = addr;
      cur_wdata = wdata;
    end
  end

  // Detect the edge that moves the FSM into DONE; the array access happens on that edge.
  always_comb begin
    enter_done = 1'b0;
    case (state)
      S_IDLE:  enter_done = Enable && (WAIT_CYC == 0);
      S_WAIT:  enter_done = (cnt == CNT_W'(1));
      default: enter_done = 1'b0;
    endcase
  end

  // MFC only if the initiator is still requesting on the entry edge and never dropped out in WAIT.
  assign mfc_on = enter_done && Enable && !aborted;

  // Word index: modulo DEPTH so out-of-range addresses alias when bounds checking is off.
  assign acc_idx = IDX_W'(32'(cur_addr) % DEPTH);

`ifdef MEM_BOUNDS_EN
  assign acc_oob = (32'(cur_addr) >= DEPTH);
`else
  assign acc_oob = 1'b0;
`endif

  // Gated by reset so an edge during reset can never commit a write.
  assign mem_we = enter_done && !cur_rw && !acc_oob && reset;

  // Storage array write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[acc_idx] <= cur_wdata;
    end
  end

  // Handshake FSM with registered MFC/busy/rdata (and err).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      lat_rw    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      aborted   <= 1'b0;
      MFC       <= 1'b0;
      busy      <= 1'b0;
      rdata     <= '0;
`ifdef MEM_BOUNDS_EN
      err       <= 1'b0;
`endif
    end else begin
      if (enter_done && cur_rw) begin
        rdata <= acc_oob ? '0 : mem[acc_idx];
      end

      case (state)
        S_IDLE: begin
          if (Enable) begin
            lat_rw    <= RW;
            lat_addr  <= addr;
            lat_wdata <= wdata;
            cnt       <= CNT_W'(WAIT_CYC);
            busy      <= 1'b1;
            if (WAIT_CYC == 0) begin
              state <= S_DONE;
              MFC   <= mfc_on;
`ifdef MEM_BOUNDS_EN
              err   <= mfc_on && acc_oob;
`endif
            end else begin
              state <= S_WAIT;
            end
          end
        end

        S_WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (!Enable) begin
            aborted <= 1'b1;
          end
          if (enter_done) begin
            state <= S_DONE;
            MFC   <= mfc_on;
`ifdef MEM_BOUNDS_EN
            err   <= mfc_on && acc_oob;
`endif
          end
        end

        S_DONE: begin
          if (!Enable || aborted) begin
            state <= S_RELEASE;
            MFC   <= 1'b0;
`ifdef MEM_BOUNDS_EN
            err   <= 1'b0;
`endif
          end
        end

        S_RELEASE: begin
          state   <= S_IDLE;
          busy    <= 1'b0;
          aborted <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
          MFC   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
